// File: rtl/wb_trace_buffer_if.sv
// Commit-stream and trace read-port bundle for wb_trace_buffer.
// The master side is the core plus the debug host; the slave side is the buffer.
interface wb_trace_buffer_if;
  logic [31:0] wb_pc;
  logic        wb_rf_wen;
  logic [4:0]  wb_rf_addr;
  logic [31:0] wb_rf_wdata;
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_pc;
  logic [4:0]  rd_addr;
  logic [31:0] rd_wdata;

  modport master (
    output wb_pc, wb_rf_wen, wb_rf_addr, wb_rf_wdata, rd_ready,
    input  rd_valid, rd_pc, rd_addr, rd_wdata
  );

  modport slave (
    input  wb_pc, wb_rf_wen, wb_rf_addr, wb_rf_wdata, rd_ready,
    output rd_valid, rd_pc, rd_addr, rd_wdata
  );
endinterface

// File: rtl/wb_trace_buffer.sv
// Trigger-gated FIFO of committed register writes, drained through a FWFT valid/ready port.
// Optional WB_TRACE_ZERO_FILTER_EN: commits to x0 are ignored entirely.
module wb_trace_buffer #(
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter int DROP_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  wb_trace_buffer_if.slave  bus,
  input  logic              arm,
  input  logic [31:0]       trig_pc,
  input  logic              stop_on_full,
  output logic [AW:0]       count,
  output logic [1:0]        state,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  state_t cur_state, next_state;

  logic [31:0] mem_pc    [DEPTH];
  logic [4:0]  mem_addr  [DEPTH];
  logic [31:0] mem_wdata [DEPTH];

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          is_record, trig_hit, not_empty, full;
  logic          push_req, push_ok, push_refused, pop_ok;

`ifdef WB_TRACE_ZERO_FILTER_EN
  assign is_record = bus.wb_rf_wen && (bus.wb_rf_addr != 5'd0);
`else
  assign is_record = bus.wb_rf_wen;
`endif

  assign trig_hit  = is_record && (bus.wb_pc == trig_pc);
  assign not_empty = (count != '0);
  assign full      = (count == FULL_COUNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur_state <= IDLE;
    else        cur_state <= next_state;
  end

  always_comb begin
    next_state = cur_state;
    if (arm) begin
      next_state = WAIT;
    end else begin
      unique case (cur_state)
        IDLE:    next_state = IDLE;
        WAIT:    if (trig_hit) next_state = CAPTURE;
        CAPTURE: if (push_refused && stop_on_full) next_state = DONE;
        DONE:    next_state = DONE;
        default: next_state = IDLE;
      endcase
    end
  end

  // arm overrides everything in the cycle, so a same-cycle record or pop never lands.
  always_comb begin
    state        = cur_state;
    push_req     = 1'b0;
    push_ok      = 1'b0;
    push_refused = 1'b0;
    pop_ok       = 1'b0;
    if (!arm) begin
      pop_ok = not_empty && bus.rd_ready;
      unique case (cur_state)
        WAIT:    push_req = trig_hit;
        CAPTURE: push_req = is_record;
        default: push_req = 1'b0;
      endcase
      push_ok      = push_req && (!full || pop_ok);
      push_refused = push_req && full && !pop_ok;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (arm) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_refused) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_pc[wr_ptr]    <= bus.wb_pc;
      mem_addr[wr_ptr]  <= bus.wb_rf_addr;
      mem_wdata[wr_ptr] <= bus.wb_rf_wdata;
    end
  end

  // Storage is not reset, so the head is masked to zero whenever the buffer is empty.
  assign bus.rd_valid = not_empty;
  assign bus.rd_pc    = not_empty ? mem_pc[rd_ptr]    : 32'd0;
  assign bus.rd_addr  = not_empty ? mem_addr[rd_ptr]  : 5'd0;
  assign bus.rd_wdata = not_empty ? mem_wdata[rd_ptr] : 32'd0;

endmodule
